// File: rtl/rcpu_pkg.sv
// Shared register-file definitions: default lane width, lane-count helper and
// the half-mask encodings of the 16-bit configuration.
package rcpu_pkg;

    localparam int LANE_W = 8;

    function automatic int lanes(input int w, input int lane_w);
        return w / lane_w;
    endfunction

    localparam int LANES_16 = lanes(16, LANE_W);

    typedef logic [LANES_16-1:0] lane_mask_t;

    localparam lane_mask_t MASK_FULL = 2'b11;
    localparam lane_mask_t MASK_LO   = 2'b01;
    localparam lane_mask_t MASK_HI   = 2'b10;

endpackage

// File: rtl/lane_merge.sv
// Combinational lane merge: a full mask writes the word through unchanged;
// a partial mask broadcasts one source lane into every enabled lane.
module lane_merge
    import rcpu_pkg::*;
#(
    parameter int W      = 16,
    parameter int LANE_W = rcpu_pkg::LANE_W,
    localparam int L     = rcpu_pkg::lanes(W, LANE_W),
    localparam int SW    = (L > 1) ? $clog2(L) : 1
) (
    input  logic [W-1:0]  cur,
    input  logic [W-1:0]  wr_data,
    input  logic [L-1:0]  wr_mask,
    input  logic [SW-1:0] wr_src_lane,
    output logic [W-1:0]  next
);

    logic              full_mask;
    logic [LANE_W-1:0] src_lane;

    assign full_mask = &wr_mask;

    // Source indices with no matching lane leave src_lane at zero.
    always_comb begin
        src_lane = '0;
        for (int i = 0; i < L; i++) begin
            if (wr_src_lane == SW'(i)) begin
                src_lane = wr_data[i*LANE_W +: LANE_W];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < L; gi++) begin : g_lane
            assign next[gi*LANE_W +: LANE_W] =
                full_mask    ? wr_data[gi*LANE_W +: LANE_W] :
                wr_mask[gi]  ? src_lane :
                               cur[gi*LANE_W +: LANE_W];
        end
    endgenerate

endmodule

// File: rtl/regfile_lanes.sv
// Lane-writable register file with two async read ports and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes/clears to the read ports.
module regfile_lanes
    import rcpu_pkg::*;
#(
    parameter int W        = 16,
    parameter int LANE_W   = rcpu_pkg::LANE_W,
    parameter int DEPTH    = 8,
    parameter bit ZERO_REG = 1'b0,
    localparam int L       = rcpu_pkg::lanes(W, LANE_W),
    localparam int A       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int SW      = (L > 1) ? $clog2(L) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [A-1:0]  rd0_addr,
    input  logic [A-1:0]  rd1_addr,
    output logic [W-1:0]  rd0_data,
    output logic [W-1:0]  rd1_data,
    output logic          rd0_busy,
    output logic          rd1_busy,
    input  logic          wr_en,
    input  logic [A-1:0]  wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [L-1:0]  wr_mask,
    input  logic [SW-1:0] wr_src_lane,
    input  logic          wr_clr,
    input  logic          rsv_en,
    input  logic [A-1:0]  rsv_addr,
    output logic          busy_any
);

    logic [W-1:0]     value_reg  [DEPTH];
    logic [W-1:0]     value_next [DEPTH];
    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;

    logic [DEPTH-1:0] wr_hit;
    logic [DEPTH-1:0] rsv_hit;
    logic [W-1:0]     wr_cur;
    logic [W-1:0]     wr_next;

    // Out-of-range addresses simply match no row, so they read as zero.
    always_comb begin
        wr_cur = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr == A'(i)) begin
                wr_cur = value_reg[i];
            end
        end
    end

    lane_merge #(
        .W      (W),
        .LANE_W (LANE_W)
    ) u_wr_merge (
        .cur         (wr_cur),
        .wr_data     (wr_data),
        .wr_mask     (wr_mask),
        .wr_src_lane (wr_src_lane),
        .next        (wr_next)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_row
            localparam bit LOCKED = ZERO_REG && (gi == 0);

            assign wr_hit[gi]  = !LOCKED && wr_en  && (wr_addr  == A'(gi));
            assign rsv_hit[gi] = !LOCKED && rsv_en && (rsv_addr == A'(gi));

            assign value_next[gi] = wr_hit[gi] ? wr_next : value_reg[gi];
            // A reservation is younger than the completing write, so set wins.
            assign busy_next[gi]  = rsv_hit[gi] | (busy_reg[gi] & ~(wr_hit[gi] & wr_clr));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                value_reg[i] <= '0;
            end
            busy_reg <= '0;
        end else begin
            value_reg <= value_next;
            busy_reg  <= busy_next;
        end
    end

    assign busy_any = |busy_reg;

    logic [A-1:0] rd_addr [2];
    logic [W-1:0] rd_data [2];
    logic [1:0]   rd_busy;

    assign rd_addr[0] = rd0_addr;
    assign rd_addr[1] = rd1_addr;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [W-1:0] cur_data;
            logic         cur_busy;

            always_comb begin
                cur_data = '0;
                cur_busy = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (rd_addr[gi] == A'(i)) begin
                        cur_data = value_reg[i];
                        cur_busy = busy_reg[i];
                    end
                end
            end

`ifdef REGFILE_BYPASS_EN
            logic [W-1:0] merged;
            logic         fwd;
            logic         rsv_same;

            lane_merge #(
                .W      (W),
                .LANE_W (LANE_W)
            ) u_rd_merge (
                .cur         (cur_data),
                .wr_data     (wr_data),
                .wr_mask     (wr_mask),
                .wr_src_lane (wr_src_lane),
                .next        (merged)
            );

            assign fwd         = (|wr_hit)  && (rd_addr[gi] == wr_addr);
            assign rsv_same    = (|rsv_hit) && (rd_addr[gi] == rsv_addr);
            assign rd_data[gi] = fwd ? merged : cur_data;
            assign rd_busy[gi] = cur_busy & ~(fwd & wr_clr & ~rsv_same);
`else
            assign rd_data[gi] = cur_data;
            assign rd_busy[gi] = cur_busy;
`endif
        end
    endgenerate

    assign rd0_data = rd_data[0];
    assign rd1_data = rd_data[1];
    assign rd0_busy = rd_busy[0];
    assign rd1_busy = rd_busy[1];

endmodule

// File: tb/tb_regfile_lanes.sv
// Directed and random checks of regfile_lanes (ZERO_REG=1) against a
// scoreboard fed by a behavioural reference model.
module tb_regfile_lanes;
    import rcpu_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  rd0_addr, rd1_addr, wr_addr, rsv_addr;
    logic [15:0] rd0_data, rd1_data, wr_data;
    logic        rd0_busy, rd1_busy, busy_any;
    logic        wr_en, wr_clr, rsv_en;
    lane_mask_t  wr_mask;
    logic [0:0]  wr_src_lane;

    always #5 clk = ~clk;

    regfile_lanes #(
        .W        (16),
        .LANE_W   (8),
        .DEPTH    (8),
        .ZERO_REG (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd0_addr    (rd0_addr),
        .rd1_addr    (rd1_addr),
        .rd0_data    (rd0_data),
        .rd1_data    (rd1_data),
        .rd0_busy    (rd0_busy),
        .rd1_busy    (rd1_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_mask     (wr_mask),
        .wr_src_lane (wr_src_lane),
        .wr_clr      (wr_clr),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .busy_any    (busy_any)
    );

    typedef struct packed {
        logic [15:0] d0;
        logic [15:0] d1;
        logic        b0;
        logic        b1;
        logic        any;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] mval [8];
    logic [7:0]  mbusy;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] mmerge(input logic [15:0] cur, input logic [15:0] d,
                                           input logic [1:0] m, input logic s);
        logic [7:0]  src;
        logic [15:0] r;
        if (m == 2'b11) return d;
        src = s ? d[15:8] : d[7:0];
        r = cur;
        if (m[0]) r[7:0]  = src;
        if (m[1]) r[15:8] = src;
        return r;
    endfunction

    task automatic model_read(input logic [2:0] a, output logic [15:0] d, output logic b);
        d = mval[a];
        b = mbusy[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && a == wr_addr && a != 3'd0) begin
            d = mmerge(mval[a], wr_data, wr_mask, wr_src_lane[0]);
            if (wr_clr && !(rsv_en && rsv_addr == a)) b = 1'b0;
        end
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mval[i] = 16'h0;
        mbusy = 8'h0;
    endtask

    // Drive one cycle's inputs, push the expected read-side view, then compare
    // it on the falling edge.
    task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input lane_mask_t wm, input logic ws, input logic wc,
                         input logic re, input logic [2:0] ra,
                         input logic [2:0] a0, input logic [2:0] a1);
        exp_t        e;
        exp_t        got;
        logic [15:0] d;
        logic        b;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm; wr_src_lane = ws;
        wr_clr = wc; rsv_en = re; rsv_addr = ra; rd0_addr = a0; rd1_addr = a1;
        model_read(a0, d, b); e.d0 = d; e.b0 = b;
        model_read(a1, d, b); e.d1 = d; e.b1 = b;
        e.any = |mbusy;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 16'd0, 16'd1);
        end else begin
            got = sb.pop_front();
            chk("rd0_data", rd0_data, got.d0);
            chk("rd1_data", rd1_data, got.d1);
            chk("rd0_busy", {15'b0, rd0_busy}, {15'b0, got.b0});
            chk("rd1_busy", {15'b0, rd1_busy}, {15'b0, got.b1});
            chk("busy_any", {15'b0, busy_any}, {15'b0, got.any});
        end
        $display("txn we=%0d wa=%0d wd=%h m=%b s=%0d clr=%0d rsv=%0d ra=%0d | rd0[%0d]=%h/%0d rd1[%0d]=%h/%0d any=%0d",
                 we, wa, wd, wm, ws, wc, re, ra, a0, rd0_data, rd0_busy, a1, rd1_data, rd1_busy, busy_any);
    endtask

    task automatic idle(input logic [2:0] a0, input logic [2:0] a1);
        drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, a0, a1);
    endtask

    task automatic tick();
        @(posedge clk);
        if (wr_en && wr_addr != 3'd0) begin
            mval[wr_addr] = mmerge(mval[wr_addr], wr_data, wr_mask, wr_src_lane[0]);
            if (wr_clr) mbusy[wr_addr] = 1'b0;
        end
        if (rsv_en && rsv_addr != 3'd0) mbusy[rsv_addr] = 1'b1;
        #1;
    endtask

    initial begin
        wr_en = 0; wr_addr = 0; wr_data = 0; wr_mask = 0; wr_src_lane = 0;
        wr_clr = 0; rsv_en = 0; rsv_addr = 0; rd0_addr = 3'd3; rd1_addr = 3'd5;
        model_reset();

        #2;
        chk("reset_rd0_data", rd0_data, 16'h0);
        chk("reset_rd1_busy", {15'b0, rd1_busy}, 16'h0);
        chk("reset_busy_any", {15'b0, busy_any}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write r3, reserve r5, then reset asynchronously between edges.
        drive(1'b1, 3'd3, 16'hBEEF, MASK_FULL, 1'b0, 1'b0, 1'b1, 3'd5, 3'd3, 3'd5);
        tick();
        idle(3'd3, 3'd5);
        chk("r3_written", rd0_data, 16'hBEEF);
        chk("r5_busy", {15'b0, rd1_busy}, 16'h1);
        chk("busy_any_set", {15'b0, busy_any}, 16'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_r3", rd0_data, 16'h0);
        chk("async_rst_r5_busy", {15'b0, rd1_busy}, 16'h0);
        chk("async_rst_busy_any", {15'b0, busy_any}, 16'h0);
        model_reset();
        #1;
        rst_n = 1'b1;
        tick();

        // Full write, then the two partial broadcast writes.
        drive(1'b1, 3'd2, 16'h1234, MASK_FULL, 1'b0, 1'b0, 1'b0, 3'd0, 3'd2, 3'd2);
        chk("same_cycle_r2", rd0_data, BYP ? 16'h1234 : 16'h0000);
        tick();
        idle(3'd2, 3'd3);
        chk("full_write_r2", rd0_data, 16'h1234);
        tick();
        drive(1'b1, 3'd2, 16'hAB00, MASK_LO, 1'b1, 1'b0, 1'b0, 3'd0, 3'd2, 3'd1);
        tick();
        idle(3'd2, 3'd1);
        chk("partial_lo_r2", rd0_data, 16'h12AB);
        tick();
        drive(1'b1, 3'd2, 16'h00CD, MASK_HI, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 3'd2);
        tick();
        idle(3'd1, 3'd2);
        chk("partial_hi_r2", rd1_data, 16'hCDAB);
        tick();

        // Scoreboard: reserve, complete, then reserve+complete together.
        drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b1, 3'd4, 3'd4, 3'd2);
        tick();
        idle(3'd4, 3'd2);
        chk("rsv_r4_busy", {15'b0, rd0_busy}, 16'h1);
        chk("rsv_busy_any", {15'b0, busy_any}, 16'h1);
        tick();
        drive(1'b1, 3'd4, 16'h5555, 2'b00, 1'b0, 1'b1, 1'b0, 3'd0, 3'd4, 3'd2);
        tick();
        idle(3'd4, 3'd2);
        chk("clr_r4_busy", {15'b0, rd0_busy}, 16'h0);
        chk("clr_busy_any", {15'b0, busy_any}, 16'h0);
        chk("mask0_r4_value", rd0_data, 16'h0);
        tick();
        drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b1, 3'd4, 3'd4, 3'd2);
        tick();
        drive(1'b1, 3'd4, 16'h0, 2'b00, 1'b0, 1'b1, 1'b1, 3'd4, 3'd4, 3'd2);
        tick();
        idle(3'd4, 3'd2);
        chk("set_wins_r4_busy", {15'b0, rd0_busy}, 16'h1);
        tick();
        drive(1'b1, 3'd4, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0, 3'd0, 3'd4, 3'd2);
        tick();

        // Register 0 is hardwired to zero and never busy.
        drive(1'b1, 3'd0, 16'hFFFF, MASK_FULL, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0);
        tick();
        idle(3'd0, 3'd0);
        chk("zero_reg_data", rd0_data, 16'h0);
        chk("zero_reg_busy", {15'b0, rd1_busy}, 16'h0);
        chk("zero_reg_busy_any", {15'b0, busy_any}, 16'h0);
        tick();

        for (int n = 0; n < 10000; n++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom()),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
